// File: rtl/memory_burst_pkg.sv
// memory_burst_pkg: FSM encodings, default sizing constants and width helper shared by memory_burst.
package memory_burst_pkg;
  typedef enum logic [1:0] {MEM_ST_IDLE, MEM_ST_WAIT, MEM_ST_XFER} mem_state_e;
  localparam int MEM_SIZE_DEF = 65536;
  localparam int LATENCY_DEF = 3;
  function automatic int beat_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/memory_burst_addr_gen.sv
// memory_burst_addr_gen: registered line base and beat counter, critical-word-first wrapped addresses.
module memory_burst_addr_gen import memory_burst_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int BURST_LEN = 4,
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          step,
  input  logic                          first,
  input  logic [ADDR_WIDTH-1:0]         addr,
  output logic [ADDR_WIDTH-1:0]         beat_addr,
  output logic [ADDR_WIDTH-1:0]         next_addr,
  output logic [beat_w(BURST_LEN)-1:0]  beat_idx,
  output logic                          last_beat,
  output logic                          oor,
  output logic                          next_oor
);
  localparam int IW = beat_w(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] LMASK = ADDR_WIDTH'(BURST_LEN - 1);
  logic [ADDR_WIDTH-1:0] base, src, nidx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      beat_idx <= '0;
    end else begin
      if (load) base <= addr;
      if (step) beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
    end
  // next_addr looks one beat ahead so rdata can be registered into the beat cycle
  assign src = load ? addr : base;
  assign nidx = first ? '0 : ADDR_WIDTH'(beat_idx) + ADDR_WIDTH'(1);
  assign next_addr = (src & ~LMASK) | ((src + nidx) & LMASK);
  assign beat_addr = (base & ~LMASK) | ((base + ADDR_WIDTH'(beat_idx)) & LMASK);
  assign last_beat = beat_idx == IW'(BURST_LEN - 1);
  assign oor = 32'(base & ~LMASK) >= 32'(MEM_SIZE);
  assign next_oor = 32'(src & ~LMASK) >= 32'(MEM_SIZE);
endmodule

// File: rtl/memory_burst.sv
// memory_burst: word-addressed SRAM model serving wrapped bursts with latency, byte lanes and req/ack.
// Optional MEM_DATA_CHECK_EN flags X/Z write data and Z read data, then stops the simulation.
module memory_burst import memory_burst_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int BURST_LEN = 4,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wbe,
  output logic                          ack,
  output logic                          busy,
  output logic                          dvalid,
  output logic                          dready,
  output logic [beat_w(BURST_LEN)-1:0]  beat_idx,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int MW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  mem_state_e state;
  logic [15:0] wcnt;
  logic we_q, accept, first, beat_next, we_src, last_beat, oor, next_oor, chk;
  logic [ADDR_WIDTH-1:0] beat_addr, next_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  memory_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN), .MEM_SIZE(MEM_SIZE)) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .load(accept), .step(state == MEM_ST_XFER), .first(first), .addr(addr),
    .beat_addr(beat_addr), .next_addr(next_addr), .beat_idx(beat_idx), .last_beat(last_beat),
    .oor(oor), .next_oor(next_oor)
  );
  assign accept = state == MEM_ST_IDLE && req;
  assign first = (accept && LATENCY == 1) || (state == MEM_ST_WAIT && wcnt == 16'(LATENCY - 2));
  assign beat_next = first || (state == MEM_ST_XFER && !last_beat);
  assign we_src = accept ? we : we_q;
  assign rd_word = mem[next_addr[MW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MEM_ST_IDLE;
      wcnt <= '0;
      we_q <= 1'b0;
      ack <= 1'b0;
      busy <= 1'b0;
      dvalid <= 1'b0;
      dready <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= accept ? (LATENCY == 1 ? MEM_ST_XFER : MEM_ST_WAIT) : first ? MEM_ST_XFER :
               (state == MEM_ST_XFER && last_beat) ? MEM_ST_IDLE : state;
      wcnt <= state == MEM_ST_WAIT ? wcnt + 16'd1 : '0;
      if (accept) we_q <= we;
      ack <= accept;
      busy <= accept || (state != MEM_ST_IDLE && !(state == MEM_ST_XFER && last_beat));
      dvalid <= beat_next && !we_src;
      dready <= beat_next && we_src;
      if (beat_next && !we_src) rdata <= next_oor ? '0 : rd_word;
      err <= err || (accept && next_oor) || chk;
    end
  // the array has no reset so committed beats survive rst_n
  always_ff @(posedge clk)
    if (dready && !oor)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) mem[beat_addr[MW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
`ifdef MEM_DATA_CHECK_EN
  logic wr_bad, rd_bad;
  always_comb begin
    wr_bad = 1'b0;
    rd_bad = 1'b0;
    for (int i = 0; i < NB; i++)
      if (dready && wbe[i] && $isunknown(wdata[8*i +: 8])) wr_bad = 1'b1;
    for (int b = 0; b < DATA_WIDTH; b++)
      if (beat_next && !we_src && !next_oor && rd_word[b] === 1'bz) rd_bad = 1'b1;
  end
  assign chk = wr_bad || rd_bad;
  always @(posedge clk)
    if (rst_n && chk) begin
      $display("%0t memory_burst data check at address %h", $time, wr_bad ? beat_addr : next_addr);
      $stop;
    end
`else
  assign chk = 1'b0;
`endif
endmodule
